// File: rtl/tile_palette_mux.sv
// tile_palette_mux: two-stage pipelined tile-index to colour selector with a
// run-time writable palette, fixed background for index 0, and a frame-paced
// blink that inverts one highlighted tile on alternate blink periods.
module tile_palette_mux #(
  parameter int                 DATA_W       = 12,
  parameter int                 N_CH         = 15,
  parameter int                 SEL_W        = 5,
  parameter logic [DATA_W-1:0]  BG_COLOR     = 12'hFFF,
  parameter int                 BLINK_FRAMES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [SEL_W-1:0]  sel,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              hl_en,
  input  logic [SEL_W-1:0]  hl_idx,
  input  logic              frame_tick,
  output logic [DATA_W-1:0] dout,
  output logic              out_valid,
  output logic              blink_phase
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [DATA_W-1:0] pal [1:N_CH];
  logic [DATA_W-1:0] lookup_color;
  logic              s1_valid;
  logic [SEL_W-1:0]  s1_sel;
  logic [DATA_W-1:0] s1_color;
  logic              hl_hit;
  logic [CNT_W-1:0]  frame_cnt;

  // Palette registers; addresses 0 and above N_CH match no entry and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i <= N_CH; i++) pal[i] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 1; i <= N_CH; i++)
        if (wr_addr == SEL_W'(i)) pal[i] <= wr_data;
    end
  end

  // Colour lookup: background for 0, palette entry otherwise, clamp past N_CH.
  always_comb begin
    lookup_color = pal[N_CH];
    if (sel == '0) begin
      lookup_color = BG_COLOR;
    end else begin
      for (int unsigned i = 1; i <= N_CH; i++)
        if (sel == SEL_W'(i)) lookup_color = pal[i];
    end
  end

  // Stage 1: capture pixel slot and looked-up colour (pre-write palette value).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sel   <= '0;
      s1_color <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_sel   <= sel;
      s1_color <= lookup_color;
    end
  end

  // Highlight match uses live hl_en/hl_idx; index 0 (background) never blinks.
  always_comb begin
    hl_hit = s1_valid && hl_en && blink_phase &&
             (s1_sel == hl_idx) && (hl_idx != '0);
  end

  // Stage 2: blank inactive slots, invert the highlighted tile when in phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dout      <= '0;
    end else begin
      out_valid <= s1_valid;
      if (!s1_valid)   dout <= '0;
      else if (hl_hit) dout <= ~s1_color;
      else             dout <= s1_color;
    end
  end

  // Blink pacing: count frame ticks while highlighting, toggle phase on wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!hl_en) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (frame_cnt == CNT_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tile_palette_mux.sv
// Testbench for tile_palette_mux: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the palette/blink rules.
module tb_tile_palette_mux;

  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  sel = '0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        hl_en = 1'b0;
  logic [4:0]  hl_idx = '0;
  logic        frame_tick = 1'b0;
  logic [11:0] dout;
  logic        out_valid;
  logic        blink_phase;

  tile_palette_mux #(
    .DATA_W(12), .N_CH(15), .SEL_W(5), .BG_COLOR(12'hFFF), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sel(sel),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .hl_en(hl_en), .hl_idx(hl_idx), .frame_tick(frame_tick),
    .dout(dout), .out_valid(out_valid), .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Model state: palette contents, pixels in flight, frame ticks while enabled.
  typedef struct { bit v; int s; int c; } pix_t;
  int   m_pal [0:15];
  pix_t m_pipe [$];
  int   m_ticks;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_phase();
    return (m_ticks / BF) % 2;
  endfunction

  task automatic model_reset();
    pix_t z;
    z.v = 0; z.s = 0; z.c = 0;
    for (int i = 0; i < 16; i++) m_pal[i] = 0;
    m_pipe.delete();
    m_pipe.push_back(z);
    m_ticks = 0;
  endtask

  // One clock: update the model with the inputs held across the edge, then check.
  task automatic step();
    pix_t p, n;
    int   e_dout, e_ov;
    @(posedge clk);
    p = m_pipe.pop_front();
    e_ov = p.v;
    if (!p.v) e_dout = 0;
    else if (hl_en && m_phase() == 1 && p.s == int'(hl_idx) && hl_idx != 0)
      e_dout = (~p.c) & 12'hFFF;
    else e_dout = p.c;
    n.v = in_valid;
    n.s = int'(sel);
    n.c = (sel == 0) ? 12'hFFF : m_pal[(int'(sel) > 15) ? 15 : int'(sel)];
    m_pipe.push_back(n);
    if (wr_en && wr_addr >= 1 && wr_addr <= 15) m_pal[int'(wr_addr)] = int'(wr_data);
    if (!hl_en) m_ticks = 0;
    else if (frame_tick) m_ticks++;
    #1;
    check("dout", 32'(dout), 32'(e_dout));
    check("out_valid", 32'(out_valid), 32'(e_ov));
    check("blink_phase", 32'(blink_phase), 32'(m_phase()));
  endtask

  task automatic drive(input bit v, input int s, input bit he, input int hi, input bit ft);
    in_valid = v; sel = 5'(s); hl_en = he; hl_idx = 5'(hi); frame_tick = ft;
    wr_en = 1'b0;
  endtask

  task automatic do_write(input int a, input int d);
    wr_en = 1'b1; wr_addr = 5'(a); wr_data = 12'(d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int rd_sel [5] = '{0, 5, 15, 18, 31};
  int rd_exp [5] = '{12'hFFF, 12'h0F0, 12'hABC, 12'hABC, 12'hABC};

  initial begin
    do_reset();
    check("reset_dout", 32'(dout), 32'h0);
    check("reset_valid", 32'(out_valid), 32'h0);
    check("reset_phase", 32'(blink_phase), 32'h0);

    // Write/read including clamp.
    drive(0, 0, 0, 0, 0); do_write(5, 12'h0F0); step();
    drive(0, 0, 0, 0, 0); do_write(15, 12'hABC); step();
    for (int i = 0; i < 7; i++) begin
      drive(i < 5, (i < 5) ? rd_sel[i] : 0, 0, 0, 0);
      step();
      if (i >= 1 && i <= 5) begin
        check("rd_dout", 32'(dout), 32'(rd_exp[i-1]));
        check("rd_valid", 32'(out_valid), 32'h1);
      end
    end

    // Illegal writes are ignored.
    drive(0, 0, 0, 0, 0); do_write(0, 12'h123); step();
    drive(0, 0, 0, 0, 0); do_write(20, 12'h777); step();
    drive(1, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0); step();
    check("bg_after_wr0", 32'(dout), 32'hFFF);
    drive(1, 20, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0); step();
    check("clamp_after_wr20", 32'(dout), 32'hABC);

    // Same-cycle write and read of pal[2].
    drive(1, 2, 0, 0, 0); do_write(2, 12'h111); step();
    drive(1, 2, 0, 0, 0); step();
    check("same_cycle_old", 32'(dout), 32'h000);
    drive(0, 0, 0, 0, 0); step();
    check("same_cycle_new", 32'(dout), 32'h111);

    // Blanking.
    drive(0, 0, 0, 0, 0); do_write(4, 12'h456); step();
    drive(0, 4, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0); step();
    check("blank_dout", 32'(dout), 32'h0);
    check("blank_valid", 32'(out_valid), 32'h0);

    // Mid-stream reset.
    drive(1, 5, 0, 0, 0); step();
    drive(1, 5, 0, 0, 0); step();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dout", 32'(dout), 32'h0);
    check("async_rst_valid", 32'(out_valid), 32'h0);
    check("async_rst_phase", 32'(blink_phase), 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1, 3, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0); step();
    check("post_rst_pal", 32'(dout), 32'h0);

    // Blink.
    drive(0, 0, 0, 0, 0); do_write(7, 12'h0F3); step();
    drive(0, 0, 0, 0, 0); do_write(6, 12'h246); step();
    drive(1, 7, 1, 7, 0); step();
    drive(1, 7, 1, 7, 1); step();
    drive(1, 7, 1, 7, 0); step();
    check("blink_pre", 32'(dout), 32'h0F3);
    drive(1, 7, 1, 7, 1); step();
    check("blink_phase_on", 32'(blink_phase), 32'h1);
    drive(1, 6, 1, 7, 0); step();
    check("blink_inv", 32'(dout), 32'hF0C);
    drive(1, 7, 1, 7, 0); step();
    check("blink_other", 32'(dout), 32'h246);
    drive(1, 7, 1, 7, 1); step();
    drive(1, 7, 1, 7, 1); step();
    check("blink_phase_off", 32'(blink_phase), 32'h0);
    drive(1, 7, 1, 7, 0); step();
    check("blink_restore", 32'(dout), 32'h0F3);
    drive(1, 7, 1, 7, 1); step();
    drive(1, 7, 1, 7, 1); step();
    check("blink_phase_on2", 32'(blink_phase), 32'h1);

    // Clear wins over tick.
    drive(1, 7, 0, 7, 1); step();
    check("clear_phase", 32'(blink_phase), 32'h0);
    drive(1, 7, 1, 7, 0); step();
    check("clear_no_inv", 32'(dout), 32'h0F3);
    drive(1, 7, 1, 7, 1); step();
    drive(1, 7, 1, 7, 0); step();
    check("clear_cnt_restart", 32'(blink_phase), 32'h0);

    // Background never inverted, even with hl_idx = 0.
    drive(1, 0, 1, 0, 1); step();
    drive(1, 0, 1, 0, 1); step();
    drive(1, 0, 1, 0, 0); step();
    check("bg_phase", 32'(blink_phase), 32'h1);
    check("bg_no_inv", 32'(dout), 32'hFFF);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 31),
            $urandom_range(0, 15) != 0, $urandom_range(0, 15),
            $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) do_write($urandom_range(0, 31), $urandom_range(0, 4095));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
